// File: rtl/scanline_buffer.sv
// Double-banked 640x12 scanline buffer between a pixel shader and VGA timing; UNDERRUN_CNT_EN adds underrun_cnt.
// Latency 2 clk_pix from x/active/syncs to vga_*; wr_ready drops once a line is full and returns at the next swap.
module scanline_buffer (
    input  logic        clk_pix,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic        active,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        wr_valid,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
`ifdef UNDERRUN_CNT_EN
    output logic        underrun,
    output logic [15:0] underrun_cnt
`else
    output logic        underrun
`endif
);

    typedef enum logic {S_FILL, S_DONE} wr_state_t;

    wr_state_t   r_state;
    logic        r_bank;
    logic [9:0]  r_wr_x;
    logic        r_line_ok;
    logic        r_underrun;
    logic [11:0] r_mem0 [0:639];
    logic [11:0] r_mem1 [0:639];
    logic [11:0] r_rd_dat;
    logic        r_act_d1;
    logic        r_hs_d1;
    logic        r_vs_d1;
    logic        r_ok_d1;

    logic        w_accept;
    logic        w_swap;
    logic        w_line_done;

    assign wr_ready    = (r_state == S_FILL);
    assign w_accept    = wr_valid && wr_ready;
    assign w_swap      = active && (x == 10'd639);
    // Pixel 639 landing in the swap cycle still completes the line.
    assign w_line_done = (r_state == S_DONE) || (w_accept && (r_wr_x == 10'd639));
    assign underrun    = r_underrun;

    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            r_state    <= S_FILL;
            r_bank     <= 1'b0;
            r_wr_x     <= 10'd0;
            r_line_ok  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (w_swap) begin
            r_bank    <= ~r_bank;
            r_wr_x    <= 10'd0;
            r_state   <= S_FILL;
            r_line_ok <= w_line_done;
            if (!w_line_done) begin
                r_underrun <= 1'b1;
            end
        end else if (w_accept) begin
            r_wr_x <= r_wr_x + 10'd1;
            if (r_wr_x == 10'd639) begin
                r_state <= S_DONE;
            end
        end
    end

    // Bank storage is deliberately left unreset; r_line_ok masks stale contents.
    always_ff @(posedge clk_pix) begin
        if (resetn && w_accept) begin
            if (r_bank) begin
                r_mem1[r_wr_x] <= wr_data;
            end else begin
                r_mem0[r_wr_x] <= wr_data;
            end
        end
        if (active) begin
            r_rd_dat <= r_bank ? r_mem0[x] : r_mem1[x];
        end
    end

    // line_ok travels with the pixel so pixel 639 is gated by the old line's status.
    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            r_act_d1  <= 1'b0;
            r_hs_d1   <= 1'b0;
            r_vs_d1   <= 1'b0;
            r_ok_d1   <= 1'b0;
            vga_r     <= 4'd0;
            vga_g     <= 4'd0;
            vga_b     <= 4'd0;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
        end else begin
            r_act_d1  <= active;
            r_hs_d1   <= hsync;
            r_vs_d1   <= vsync;
            r_ok_d1   <= r_line_ok;
            vga_r     <= (r_act_d1 && r_ok_d1) ? r_rd_dat[11:8] : 4'd0;
            vga_g     <= (r_act_d1 && r_ok_d1) ? r_rd_dat[7:4]  : 4'd0;
            vga_b     <= (r_act_d1 && r_ok_d1) ? r_rd_dat[3:0]  : 4'd0;
            vga_hsync <= r_hs_d1;
            vga_vsync <= r_vs_d1;
        end
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            underrun_cnt <= 16'd0;
        end else if (w_swap && !w_line_done && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/scanline_buffer.md
SCANLINE_BUFFER -- requirements
Module: scanline_buffer

Interface
REQ-001 SHALL have port clk_pix, in, 1: pixel clock; all logic on its rising edge.
REQ-002 SHALL have port resetn, in, 1: one clock; reset is synchronous and active-low.
REQ-003 SHALL have port x, in, 10: timing-generator column, 0..799.
REQ-004 SHALL have port active, in, 1: timing-generator visible-area flag.
REQ-005 SHALL have ports hsync and vsync, in, 1 each: timing-generator syncs, polarity passed through unchanged.
REQ-006 SHALL have port wr_valid, in, 1: the upstream shader presents a pixel.
REQ-007 SHALL have port wr_data, in, 12: pixel as {r[3:0], g[3:0], b[3:0]}.
REQ-008 SHALL have port wr_ready, out, 1: the buffer accepts a pixel this cycle.
REQ-009 SHALL have ports vga_r, vga_g and vga_b, out, 4 each, registered.
REQ-010 SHALL have ports vga_hsync and vga_vsync, out, 1 each, registered.
REQ-011 SHALL have port underrun, out, 1: sticky flag, set when a line was not ready at swap.

Function
REQ-012 SHALL hold two banks of 640 x 12 bits: one write bank and one read bank, selected by a single bank bit.
REQ-013 SHALL accept a write when wr_valid && wr_ready; the data goes to write-bank[wr_x], and wr_x increments.
REQ-014 SHALL run a write FSM with states FILL (wr_ready=1) and DONE (wr_ready=0); acceptance at wr_x=639 moves FILL to DONE.
REQ-015 SHALL define the swap event as active && x==639.
REQ-016 SHALL, on swap, toggle the bank bit, clear wr_x to 0, enter FILL, and latch line_ok=1 if the state was DONE, else line_ok=0.
REQ-017 SHALL treat acceptance of pixel 639 in the swap cycle as a complete line (line_ok=1, no underrun).
REQ-018 SHALL, on swap with an incomplete line, set underrun and discard the partial line, so that the next displayed line is black.
REQ-019 SHALL read read-bank[x] while active; the bank toggle takes effect the cycle after swap, so pixel 639 comes from the old bank.
REQ-020 SHALL have a fixed latency of 2 clk_pix cycles from x/active/hsync/vsync to the vga_* outputs (RAM read plus output register); syncs are delayed by the same amount.
REQ-021 SHALL drive vga_r/g/b = 0 when delayed active=0 or line_ok=0, and the RAM pixel otherwise.
REQ-022 SHALL not swap during blanking; vertical blanking gives the writer time to prefill line 0 of the next frame.
REQ-023 SHALL leave bank contents uninitialised; line_ok gates any stale data.

Reset
REQ-024 SHALL, on resetn=0 at a clock edge, set: bank=0, wr_x=0, state FILL, line_ok=0, underrun=0, sync/active pipeline to 0, and vga_* all 0.
REQ-025 SHALL display the first active line after reset black; a partially written line is abandoned on reset mid-operation.

Configuration
REQ-026 SHALL, with UNDERRUN_CNT_EN defined, add output underrun_cnt[15:0], which increments on each underrun swap, saturates at 16'hFFFF, and resets to 0.
REQ-027 SHALL, without UNDERRUN_CNT_EN, omit the underrun_cnt port and counter; all other behaviour is identical.

Verification
REQ-028 Bench SHALL cover: reset, then 640 writes of 12'hF00, then swap -> wr_ready=0 after pixel 639; the next active line shows vga_r=F, g=0, b=0 for all 640 pixels, 2 cycles after x.
REQ-029 Bench SHALL cover: only 300 pixels written before swap -> underrun=1; the next line is all black; underrun_cnt=1 when UNDERRUN_CNT_EN is defined.
REQ-030 Bench SHALL cover: pixel 639 accepted in the swap cycle -> underrun stays 0; the next line is displayed.
REQ-031 Bench SHALL cover: a ramp wr_data=x[11:0] on line n -> on line n+1, vga_{r,g,b} at cycle t+2 equals the ramp value of x(t); hsync/vsync are delayed exactly 2 cycles.
REQ-032 Bench SHALL cover: resetn low for 1 cycle during a FILL at wr_x=200 -> all outputs 0 next cycle; wr_x=0; the first post-reset line is black.
REQ-033 Bench SHALL cover: 70000 forced underruns with UNDERRUN_CNT_EN defined -> underrun_cnt holds at 16'hFFFF.
